// File: rtl/param_rr_mux.sv
// param_rr_mux: N-channel, W-bit registered multiplexer with valid/ready
// handshakes on every port. Channels are chosen either by an external
// select (mode=0) or by round-robin arbitration (mode=1). A single output
// register stage decouples the producers from the consumer.
//
// Optional feature: define MUX_COUNT_EN to add the 16-bit xfer_count port,
// which counts completed output transfers.
module param_rr_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready
`ifdef MUX_COUNT_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    // Last channel granted in round-robin mode; the search starts just after it.
    logic [SELW-1:0]  ptr;

    // Per-channel view of the packed input bus.
    logic [WIDTH-1:0] ch_data [CHANNELS];

    logic             load_en;
    logic             take;
    logic             grant_found;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             sel_in_range;
    logic [SELW:0]    cand_wide;
    logic [SELW-1:0]  cand;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_split
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    // The output register may accept new data when empty or being drained.
    assign load_en      = !out_valid || out_ready;
    assign sel_in_range = ({1'b0, sel} < (SELW+1)'(CHANNELS));
    assign take         = load_en && grant_found && !reset;

    // Pick the granted channel: external select, or first valid after ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        cand_wide   = '0;
        cand        = '0;
        if (!mode) begin
            if (sel_in_range && in_valid[sel]) begin
                grant_found = 1'b1;
                grant_idx   = sel;
                grant_data  = ch_data[sel];
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                cand_wide = {1'b0, ptr} + (SELW+1)'(k);
                if (cand_wide >= (SELW+1)'(CHANNELS)) begin
                    cand_wide = cand_wide - (SELW+1)'(CHANNELS);
                end
                cand = cand_wide[SELW-1:0];
                if (!grant_found && in_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                    grant_data  = ch_data[cand];
                end
            end
        end
    end

    // Only the granted channel sees ready, and only when the register can load.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (take && (grant_idx == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; reset discards held data.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SELW'(CHANNELS - 1);
        end else if (load_en) begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                if (mode) begin
                    ptr <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_COUNT_EN
    // Count completed output transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`else
    // Transfer counting disabled: no counter state exists in this build.
`endif

endmodule
